// File: rtl/pipelined_cla_adder_if.sv
// Operand/result stream bundle for the pipelined carry-lookahead adder.
// The master drives operand beats and accepts results; the slave is the adder.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf, zero
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor.
// Stage 1 registers per-bit propagate/generate and per-group GG/GP; stage 2
// resolves group carries, then bit carries inside each group, and registers
// sum and flags. Valid/ready on both sides, no skid buffer.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int NG = (GROUP < 1) ? 1 : WIDTH / GROUP;

    generate
        if (GROUP < 1) begin : g_bad_group
            $error("pipelined_cla_adder: GROUP must be at least 1");
        end else if (WIDTH % GROUP != 0) begin : g_bad_width
            $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
        end
    endgenerate

    // Stage 1 state
    logic             s1_valid;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [NG-1:0]    s1_gg;
    logic [NG-1:0]    s1_gp;
    logic             s1_c0;

    // Stage 2 (output) state
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;
    logic             zero_q;

    // Handshake: output stage frees up when empty or being drained.
    logic s2_adv;
    logic in_ready;
    assign s2_adv   = !out_valid_q || bus.out_ready;
    assign in_ready = !s1_valid || s2_adv;

    // Stage 1 combinational: operand conditioning, bit and group P/G.
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] g_d;
    logic [NG-1:0]    gg_d;
    logic [NG-1:0]    gp_d;
    logic             c0_d;

    // Build propagate/generate and fold each group MSB-last into GG/GP.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional or loop assignment, so no path leaves it unassigned and no
        // latch is inferred.
        b_eff = bus.sub ? ~bus.b : bus.b;
        p_d   = bus.a ^ b_eff;
        g_d   = bus.a & b_eff;
        c0_d  = bus.sub | bus.c_in;
        gg_d  = '0;
        gp_d  = '1;
        for (int k = 0; k < NG; k++) begin
            for (int i = 0; i < GROUP; i++) begin
                gg_d[k] = g_d[k*GROUP+i] | (p_d[k*GROUP+i] & gg_d[k]);
                gp_d[k] = gp_d[k] & p_d[k*GROUP+i];
            end
        end
    end

    // Stage 1 register: capture a beat only on an input transfer.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is written with non-blocking assignments so all
        // registers update together from the pre-edge values.
        if (rst) begin
            // NOTE: data registers are reset along with the valid bit so the
            // pipeline comes out of reset in a fully defined, all-zero state.
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_gg    <= '0;
            s1_gp    <= '0;
            s1_c0    <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_p  <= p_d;
                s1_g  <= g_d;
                s1_gg <= gg_d;
                s1_gp <= gp_d;
                s1_c0 <= c0_d;
            end
        end
    end

    // Stage 2 combinational: group carries, then per-bit carries.
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] bit_c;
    logic [WIDTH-1:0] sum_d;
    logic             c_out_d;
    logic             ovf_d;
    logic             zero_d;

    // Lookahead across groups, ripple within each group from its group carry.
    always_comb begin
        logic c;
        grp_c    = '0;
        bit_c    = '0;
        c        = 1'b0;
        grp_c[0] = s1_c0;
        for (int k = 0; k < NG; k++) begin
            grp_c[k+1] = s1_gg[k] | (s1_gp[k] & grp_c[k]);
        end
        for (int k = 0; k < NG; k++) begin
            c = grp_c[k];
            for (int i = 0; i < GROUP; i++) begin
                bit_c[k*GROUP+i] = c;
                c = s1_g[k*GROUP+i] | (s1_p[k*GROUP+i] & c);
            end
        end
    end

    assign sum_d   = s1_p ^ bit_c;
    assign c_out_d = grp_c[NG];
    assign ovf_d   = bit_c[WIDTH-1] ^ grp_c[NG];
    assign zero_d  = (sum_d == '0);

    // Output register: advance when free; hold result steady while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                sum_q   <= sum_d;
                c_out_q <= c_out_d;
                ovf_q   <= ovf_d;
                zero_q  <= zero_d;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Testbench for pipelined_cla_adder: directed vectors with literal results,
// plus a spec-level arithmetic model and a scoreboard checked every cycle.
`timescale 1ns/1ps
module tb_pipelined_cla_adder;
    typedef struct packed {
        logic [15:0] sum;
        logic        c_out;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(16)) bus ();
    pipelined_cla_adder_if #(.WIDTH(4))  bus4 ();

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    pipelined_cla_adder #(.WIDTH(4),  .GROUP(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int   errors  = 0;
    int   checks  = 0;
    int   out_cnt = 0;
    int   out_cnt4 = 0;
    res_t exp_q[$];
    res_t exp_q4[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Arithmetic reference: unsigned result modulo 2^w, carry/no-borrow from
    // unsigned magnitudes, overflow from the exact signed result leaving range.
    function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic sb);
        res_t r;
        int   ua, ub, sa, sbv, exact, ures;
        ua    = int'(a) & ((1 << w) - 1);
        ub    = int'(b) & ((1 << w) - 1);
        sa    = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sbv   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        ures  = sb ? ua - ub : ua + ub + int'(ci);
        exact = sb ? sa - sbv : sa + sbv + int'(ci);
        r.sum   = 16'(ures & ((1 << w) - 1));
        r.c_out = sb ? (ua >= ub) : (ures >= (1 << w));
        r.ovf   = (exact > (1 << (w - 1)) - 1) || (exact < -(1 << (w - 1)));
        r.zero  = (r.sum == 16'h0000);
        return r;
    endfunction

    // Scoreboard for the 16-bit DUT: push on input transfer, pop on output
    // transfer, and require stalled outputs to hold until accepted.
    logic prev_stall = 1'b0;
    res_t prev_res;
    always @(negedge clk) begin
        res_t got, e;
        got = {bus.sum, bus.c_out, bus.ovf, bus.zero};
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", 32'(bus.out_valid), 32'd1);
                check("stall_hold_data", 32'(got), 32'(prev_res));
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_res   = got;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h, expected no beat", got);
                end else begin
                    e = exp_q.pop_front();
                    check("result_sum", 32'(got.sum), 32'(e.sum));
                    check("result_flags", 32'({got.c_out, got.ovf, got.zero}),
                          32'({e.c_out, e.ovf, e.zero}));
                    out_cnt++;
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(16, bus.a, bus.b, bus.c_in, bus.sub));
        end
    end

    // Scoreboard for the 4-bit / 2-bit-group DUT.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            exp_q4.delete();
        end else begin
            if (bus4.out_valid && bus4.out_ready) begin
                if (exp_q4.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output4: got %0h, expected no beat", bus4.sum);
                end else begin
                    e = exp_q4.pop_front();
                    check("result4_sum", 32'(bus4.sum), 32'(e.sum));
                    check("result4_flags", 32'({bus4.c_out, bus4.ovf, bus4.zero}),
                          32'({e.c_out, e.ovf, e.zero}));
                    out_cnt4++;
                end
            end
            if (bus4.in_valid && bus4.in_ready)
                exp_q4.push_back(model(4, {12'h000, bus4.a}, {12'h000, bus4.b}, bus4.c_in, bus4.sub));
        end
    end

    // All tasks start and end just after a rising edge.
    task automatic send(input logic [15:0] aa, input logic [15:0] bb, input logic ci,
                        input logic sb, output int waited);
        bus.in_valid = 1'b1;
        bus.a        = aa;
        bus.b        = bb;
        bus.c_in     = ci;
        bus.sub      = sb;
        waited       = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(output int n);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((exp_q.size() != 0 || bus.out_valid) && n < 50);
        if (exp_q.size() != 0 || bus.out_valid) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Single beat into an empty pipe: not visible after one edge, visible after two.
    task automatic run_one(input string name, input logic [15:0] aa, input logic [15:0] bb,
                           input logic ci, input logic sb, input logic [15:0] es,
                           input logic ec, input logic eo, input logic ez);
        int w;
        send(aa, bb, ci, sb, w);
        @(negedge clk);
        check({name, "_early_valid"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_sum"}, 32'(bus.sum), 32'(es));
        check({name, "_flags"}, 32'({bus.c_out, bus.ovf, bus.zero}), 32'({ec, eo, ez}));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n, base, stalls, idx;
        logic acc;
        logic [15:0] st_a [3];
        logic [15:0] st_b [3];
        logic        st_c [3];
        logic        st_s [3];
        st_a = '{16'h1234, 16'h0F0F, 16'hA5A5};
        st_b = '{16'h1111, 16'h0005, 16'h5A5A};
        st_c = '{1'b0, 1'b0, 1'b1};
        st_s = '{1'b0, 1'b1, 1'b0};

        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0; bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.c_in = 1'b0; bus4.sub = 1'b0;
        bus4.out_ready = 1'b1;

        // Pin the model to hand-computed results.
        check("model_pin_wrap", 32'(model(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0)),
              32'({16'h0000, 1'b1, 1'b0, 1'b1}));
        check("model_pin_ovf", 32'(model(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0)),
              32'({16'h8000, 1'b0, 1'b1, 1'b0}));
        check("model_pin_sub", 32'(model(16, 16'h0003, 16'h0005, 1'b0, 1'b1)),
              32'({16'hFFFE, 1'b0, 1'b0, 1'b0}));

        // Reset state.
        #12;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_outputs", 32'({bus.sum, bus.c_out, bus.ovf, bus.zero}), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors.
        run_one("wrap_zero", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_one("signed_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_one("sub_borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_one("sub_ignores_cin", 16'h0009, 16'h0004, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0);
        run_one("group_ripple", 16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_one("full_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

        // 100 back-to-back random beats with out_ready held high.
        base   = out_cnt;
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), w);
            stalls += w;
        end
        wait_drain(n);
        check("stream_no_stall", 32'(stalls), 32'd0);
        check("stream_count", 32'(out_cnt - base), 32'd100);
        check("stream_drain_cycles", 32'(n), 32'd3);

        // Stall: out_ready low for 5 cycles with 3 beats offered.
        base = out_cnt;
        bus.out_ready = 1'b0;
        idx = 0;
        bus.in_valid = 1'b1;
        bus.a = st_a[0]; bus.b = st_b[0]; bus.c_in = st_c[0]; bus.sub = st_s[0];
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                bus.a = st_a[idx]; bus.b = st_b[idx]; bus.c_in = st_c[idx]; bus.sub = st_s[idx];
            end else begin
                bus.a = 16'($urandom);
                bus.b = 16'($urandom);
            end
        end
        check("stall_accepted", 32'(idx), 32'd2);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        check("stall_first_sum", 32'(bus.sum), 32'h2345);
        bus.out_ready = 1'b1;
        send(st_a[2], st_b[2], st_c[2], st_s[2], w);
        check("release_accept_wait", 32'(w), 32'd0);
        wait_drain(n);
        check("stall_count", 32'(out_cnt - base), 32'd3);

        // Reset with two beats in flight.
        send(16'h0100, 16'h0200, 1'b0, 1'b0, w);
        send(16'h0400, 16'h0800, 1'b0, 1'b0, w);
        check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_valid", 32'(bus.out_valid), 32'd0);
        check("async_reset_outputs", 32'({bus.sum, bus.c_out, bus.ovf, bus.zero}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_one("post_reset", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("post_reset_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Exhaustive sweep of the 4-bit, 2-bit-group configuration.
        bus4.in_valid = 1'b1;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int m = 0; m < 4; m++) begin
                    bus4.a    = 4'(a);
                    bus4.b    = 4'(b);
                    bus4.c_in = m[0];
                    bus4.sub  = m[1];
                    @(posedge clk);
                    #1;
                end
        bus4.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("exhaustive4_count", 32'(out_cnt4), 32'd1024);
        check("exhaustive4_empty", 32'(exp_q4.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
